ibex_pmp_pipe: RTL

Next-generation PMP checker: parametrised address width, region count and channel count, with one registered decision stage per channel behind a valid/ready handshake. Reports the matching region index and latches the first fault in a sticky capture register for the CSR/debug path. Sits between the IF/LSU address generators and the bus request path, fed by the CSR file's PMP config and address registers.

---
 rtl/ibex_pmp_pipe.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ibex_pmp_pipe.sv
// ibex_pmp_pipe: multi-channel PMP checker with one registered decision stage
// per channel behind a valid/ready handshake, plus a sticky first-fault
// capture register for the CSR/debug path.
//
// Optional feature macro: IBEX_PMP_FAULT_CNT_EN adds fault_cnt_o, a saturating
// 16-bit count of faulting decisions, zeroed by fault_clear_i.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   csr_pmp_cfg_i/addr_i   per-region config and byte address (bits [1:0] ignored)
//   req_*                  per-channel access request (valid/ready)
//   rsp_*                  per-channel registered decision (valid/ready)
//   fault_*                sticky capture of the first fault; fault_clear_i re-arms
//   fault_cnt_o            (IBEX_PMP_FAULT_CNT_EN only) fault counter

package ibex_pmp_pipe_pkg;
  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;
endpackage

// One channel: region match, priority select, decision and output register.
// Addresses arrive already trimmed to the compared bits [W-1:G+2].
module ibex_pmp_pipe_chan
  import ibex_pmp_pipe_pkg::*;
#(
  parameter int CW   = 32,
  parameter int NR   = 16,
  parameter int IdxW = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  pmp_cfg_t [NR-1:0]       cfg_i,
  input  logic [NR-1:0][CW-1:0]   addr_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [CW-1:0]           req_addr_i,
  input  pmp_req_e                req_type_i,
  input  priv_lvl_e               req_priv_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_err_o,
  output logic [IdxW-1:0]         rsp_region_o,
  output logic                    acc_fault_o
);

  // NAPOT: lowest compared bit is always ignored; each higher bit is ignored
  // while every bit below it (down to the lowest compared bit) is one.
  function automatic logic [CW-1:0] napot_ign(input logic [CW-1:0] a);
    logic [CW-1:0] ign;
    logic          run;
    run    = 1'b1;
    ign[0] = 1'b1;
    for (int i = 1; i < CW; i++) begin
      run    = run & a[i-1];
      ign[i] = run;
    end
    return ign;
  endfunction

  logic [NR-1:0] match, perm;

  for (genvar r = 0; r < NR; r++) begin : g_reg
    logic [CW-1:0] base, ign;
    if (r == 0) begin : g_base0
      assign base = '0;
    end else begin : g_basen
      assign base = addr_i[r-1];
    end
    assign ign = napot_ign(addr_i[r]);

    always_comb begin
      match[r] = 1'b0;
      case (cfg_i[r].mode)
        PMP_MODE_NA4:   match[r] = (req_addr_i == addr_i[r]);
        PMP_MODE_NAPOT: match[r] = ~|((req_addr_i ^ addr_i[r]) & ~ign);
        // base >= top leaves the range empty by construction
        PMP_MODE_TOR:   match[r] = (req_addr_i >= base) && (req_addr_i < addr_i[r]);
        default:        match[r] = 1'b0;
      endcase
    end

    always_comb begin
      perm[r] = 1'b0;
      case (req_type_i)
        PMP_ACC_EXEC:  perm[r] = cfg_i[r].exec;
        PMP_ACC_WRITE: perm[r] = cfg_i[r].write;
        PMP_ACC_READ:  perm[r] = cfg_i[r].read;
        default:       perm[r] = 1'b0;
      endcase
    end
  end

  logic            hit_d, perm_d, lock_d, err_d;
  logic [IdxW-1:0] idx_d;

  // Walk down so the lowest matching index is the one left standing.
  always_comb begin
    hit_d  = 1'b0;
    perm_d = 1'b0;
    lock_d = 1'b0;
    idx_d  = IdxW'(NR);
    for (int r = NR - 1; r >= 0; r--) begin
      if (match[r]) begin
        hit_d  = 1'b1;
        perm_d = perm[r];
        lock_d = cfg_i[r].lock;
        idx_d  = IdxW'(r);
      end
    end
  end

  always_comb begin
    if (!hit_d)                       err_d = (req_priv_i != PRIV_LVL_M);
    else if (req_priv_i == PRIV_LVL_M) err_d = lock_d & ~perm_d;
    else                              err_d = ~perm_d;
  end

  logic accept;
  assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign accept      = req_valid_i & req_ready_o;
  assign acc_fault_o = accept & err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o  <= 1'b0;
      rsp_err_o    <= 1'b0;
      rsp_region_o <= '0;
    end else if (accept) begin
      rsp_valid_o  <= 1'b1;
      rsp_err_o    <= err_d;
      rsp_region_o <= idx_d;
    end else if (rsp_ready_i) begin
      rsp_valid_o  <= 1'b0;
    end
  end

endmodule

module ibex_pmp_pipe
  import ibex_pmp_pipe_pkg::*;
#(
  parameter int PMPAddrWidth   = 34,
  parameter int PMPGranularity = 0,
  parameter int PMPNumChan     = 2,
  parameter int PMPNumRegions  = 16,
  localparam int IdxW  = $clog2(PMPNumRegions + 1),
  localparam int ChanW = (PMPNumChan > 1) ? $clog2(PMPNumChan) : 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  pmp_cfg_t [PMPNumRegions-1:0]               csr_pmp_cfg_i,
  input  logic [PMPNumRegions-1:0][PMPAddrWidth-1:0] csr_pmp_addr_i,
  input  logic [PMPNumChan-1:0]                      req_valid_i,
  output logic [PMPNumChan-1:0]                      req_ready_o,
  input  logic [PMPNumChan-1:0][PMPAddrWidth-1:0]    req_addr_i,
  input  pmp_req_e [PMPNumChan-1:0]                  req_type_i,
  input  priv_lvl_e [PMPNumChan-1:0]                 req_priv_i,
  output logic [PMPNumChan-1:0]                      rsp_valid_o,
  input  logic [PMPNumChan-1:0]                      rsp_ready_i,
  output logic [PMPNumChan-1:0]                      rsp_err_o,
  output logic [PMPNumChan-1:0][IdxW-1:0]            rsp_region_o,
  output logic                                       fault_valid_o,
  output logic [PMPAddrWidth-1:0]                    fault_addr_o,
  output logic [ChanW-1:0]                           fault_chan_o,
  output pmp_req_e                                   fault_type_o,
`ifdef IBEX_PMP_FAULT_CNT_EN
  output logic [15:0]                                fault_cnt_o,
`endif
  input  logic                                       fault_clear_i
);

  localparam int G  = PMPGranularity;
  localparam int CW = PMPAddrWidth - G - 2;

  logic [PMPNumRegions-1:0][CW-1:0] pmp_addr_cmp;
  logic [PMPNumChan-1:0]            acc_fault;

  for (genvar r = 0; r < PMPNumRegions; r++) begin : g_addr
    assign pmp_addr_cmp[r] = csr_pmp_addr_i[r][PMPAddrWidth-1:G+2];
  end

  // Sub-granule address bits never take part in matching.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^csr_pmp_addr_i;

  for (genvar c = 0; c < PMPNumChan; c++) begin : g_chan
    ibex_pmp_pipe_chan #(
      .CW   (CW),
      .NR   (PMPNumRegions),
      .IdxW (IdxW)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cfg_i        (csr_pmp_cfg_i),
      .addr_i       (pmp_addr_cmp),
      .req_valid_i  (req_valid_i[c]),
      .req_ready_o  (req_ready_o[c]),
      .req_addr_i   (req_addr_i[c][PMPAddrWidth-1:G+2]),
      .req_type_i   (req_type_i[c]),
      .req_priv_i   (req_priv_i[c]),
      .rsp_valid_o  (rsp_valid_o[c]),
      .rsp_ready_i  (rsp_ready_i[c]),
      .rsp_err_o    (rsp_err_o[c]),
      .rsp_region_o (rsp_region_o[c]),
      .acc_fault_o  (acc_fault[c])
    );
  end

  // Lowest faulting channel this cycle.
  logic                    cap_hit;
  logic [ChanW-1:0]        cap_chan;
  logic [PMPAddrWidth-1:0] cap_addr;
  pmp_req_e                cap_type;

  always_comb begin
    cap_hit  = 1'b0;
    cap_chan = '0;
    cap_addr = '0;
    cap_type = PMP_ACC_READ;
    for (int c = PMPNumChan - 1; c >= 0; c--) begin
      if (acc_fault[c]) begin
        cap_hit  = 1'b1;
        cap_chan = ChanW'(c);
        cap_addr = req_addr_i[c];
        cap_type = req_type_i[c];
      end
    end
  end

  // A clear in the same cycle as a new fault re-arms and captures at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_valid_o <= 1'b0;
      fault_addr_o  <= '0;
      fault_chan_o  <= '0;
      fault_type_o  <= PMP_ACC_READ;
    end else if (cap_hit && (!fault_valid_o || fault_clear_i)) begin
      fault_valid_o <= 1'b1;
      fault_addr_o  <= cap_addr;
      fault_chan_o  <= cap_chan;
      fault_type_o  <= cap_type;
    end else if (fault_clear_i) begin
      fault_valid_o <= 1'b0;
    end
  end

`ifdef IBEX_PMP_FAULT_CNT_EN
  logic [16:0] cnt_inc, cnt_sum;

  always_comb begin
    cnt_inc = '0;
    for (int c = 0; c < PMPNumChan; c++) cnt_inc = cnt_inc + 17'(acc_fault[c]);
    cnt_sum = (fault_clear_i ? 17'd0 : {1'b0, fault_cnt_o}) + cnt_inc;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         fault_cnt_o <= '0;
    else if (cnt_sum[16]) fault_cnt_o <= 16'hFFFF;
    else                 fault_cnt_o <= cnt_sum[15:0];
  end
`endif

endmodule
